// File: rtl/mem_subsystem.sv
// Memory-side stage: MAR/MDR registers plus word-addressed synchronous RAM.
// Runs mem_read/mem_write as multi-cycle transactions ending in a one-cycle mem_ready.
module mem_subsystem #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 9,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  mari,
  input  logic                  mdri,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mar_out,
  output logic [DATA_WIDTH-1:0] mdr_out,
  output logic                  busy,
  output logic                  mem_ready,
  output logic                  conflict
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CNT_WIDTH = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] mar;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] mdr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [CNT_WIDTH-1:0]  count;
  logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];

  assign mar_out   = mar;
  assign mdr_out   = mdr;
  assign busy      = (state != IDLE);
  assign mem_ready = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mar      <= '0;
      mdr      <= '0;
      addr     <= '0;
      wdata    <= '0;
      count    <= '0;
      conflict <= 1'b0;
    end else begin
      if (mari) mar <= bus_in[ADDR_WIDTH-1:0];
      case (state)
        IDLE: begin
          if (mdri) mdr <= bus_in;
          // Address and write data are the pre-edge MAR/MDR values.
          if (mem_read && mem_write) begin
            conflict <= 1'b1;
          end else if (mem_read) begin
            addr  <= mar;
            count <= CNT_WIDTH'(READ_LATENCY - 1);
            state <= RD_WAIT;
          end else if (mem_write) begin
            addr  <= mar;
            wdata <= mdr;
            count <= CNT_WIDTH'(WRITE_LATENCY - 1);
            state <= WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (count == '0) begin
            mdr   <= ram[addr];
            state <= DONE;
          end else begin
            count <= count - 1'b1;
          end
        end
        WR_WAIT: begin
          if (count == '0) state <= DONE;
          else             count <= count - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is never reset; a write held off by reset is simply dropped.
  always_ff @(posedge clock) begin
    if (!reset && state == WR_WAIT && count == '0) ram[addr] <= wdata;
  end

endmodule

// File: tb/tb_mem_subsystem.sv
// Self-checking bench for mem_subsystem: scoreboard of expected completions
// popped by a mem_ready monitor, plus per-scenario inline checks.
module tb_mem_subsystem;

  localparam int DW = 32;
  localparam int AW = 9;
  localparam int RL = 2;
  localparam int WL = 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] bus_in = '0;
  logic          mari = 1'b0;
  logic          mdri = 1'b0;
  logic          mem_read = 1'b0;
  logic          mem_write = 1'b0;
  logic [AW-1:0] mar_out;
  logic [DW-1:0] mdr_out;
  logic          busy;
  logic          mem_ready;
  logic          conflict;

  int checks = 0;
  int errors = 0;
  int ready_count = 0;

  typedef struct {
    bit            is_read;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  mem_subsystem #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .READ_LATENCY(RL),
    .WRITE_LATENCY(WL)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus_in(bus_in),
    .mari(mari),
    .mdri(mdri),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .mar_out(mar_out),
    .mdr_out(mdr_out),
    .busy(busy),
    .mem_ready(mem_ready),
    .conflict(conflict)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: every mem_ready pulse must match a queued expectation.
  always @(negedge clock) begin
    if (!reset && mem_ready) begin
      ready_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: mem_ready=1 with empty scoreboard, mdr_out=%h", mdr_out);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.is_read && mdr_out !== mon_e.data) begin
          errors++;
          $display("FAIL sb_read_data: got %h expected %h", mdr_out, mon_e.data);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic load_mar(input logic [DW-1:0] v);
    bus_in = v; mari = 1'b1; cyc(); mari = 1'b0;
  endtask

  task automatic load_mdr(input logic [DW-1:0] v);
    bus_in = v; mdri = 1'b1; cyc(); mdri = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 20) begin
      cyc();
      n++;
      if (mem_ready) break;
    end
  endtask

  task automatic do_write(input logic [DW-1:0] a, input logic [DW-1:0] d);
    int n;
    exp_t e;
    load_mar(a);
    load_mdr(d);
    mem_write = 1'b1;
    e.is_read = 1'b0; e.data = d; exp_q.push_back(e);
    wait_ready(n);
    mem_write = 1'b0;
    checks++;
    if (n != WL + 1) begin
      errors++;
      $display("FAIL write_latency: got %0d cycles expected %0d", n, WL + 1);
    end
    cyc();
    checks++;
    if (busy !== 1'b0 || mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: busy=%b mem_ready=%b expected 0/0", busy, mem_ready);
    end
  endtask

  task automatic do_read(input logic [DW-1:0] a, input logic [DW-1:0] d);
    int n;
    exp_t e;
    load_mar(a);
    load_mdr('0);
    mem_read = 1'b1;
    e.is_read = 1'b1; e.data = d; exp_q.push_back(e);
    wait_ready(n);
    mem_read = 1'b0;
    checks++;
    if (n != RL + 1) begin
      errors++;
      $display("FAIL read_latency: got %0d cycles expected %0d", n, RL + 1);
    end
    checks++;
    if (mdr_out !== d) begin
      errors++;
      $display("FAIL read_data: got %h expected %h", mdr_out, d);
    end
    cyc();
  endtask

  task automatic apply_reset();
    reset = 1'b1; cyc(); cyc(); reset = 1'b0; cyc();
  endtask

  task automatic test_reset();
    int rc;
    apply_reset();
    checks++;
    if (mar_out !== '0 || mdr_out !== '0 || busy !== 1'b0 || mem_ready !== 1'b0 || conflict !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: mar=%h mdr=%h busy=%b ready=%b conflict=%b expected all 0",
               mar_out, mdr_out, busy, mem_ready, conflict);
    end
    // Abort a read mid-RD_WAIT; no expectation queued, so any pulse is flagged.
    load_mar(32'h3);
    load_mdr(32'h5555_AAAA);
    mem_read = 1'b1;
    cyc();
    mem_read = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_busy: busy=%b expected 1", busy);
    end
    rc = ready_count;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mdr_out !== '0 || mar_out !== '0) begin
      errors++;
      $display("FAIL reset_abort: busy=%b mdr=%h mar=%h expected 0/0/0", busy, mdr_out, mar_out);
    end
    cyc(); cyc();
    reset = 1'b0;
    repeat (5) cyc();
    checks++;
    if (ready_count != rc || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_ready: pulses=%0d busy=%b expected 0 pulses busy 0", ready_count - rc, busy);
    end
  endtask

  task automatic test_write_read();
    do_write(32'h0000_0005, 32'hDEAD_BEEF);
    do_read(32'h0000_0005, 32'hDEAD_BEEF);
    do_write(32'h0000_01FF, 32'h0F0F_1234);
    do_read(32'h0000_01FF, 32'h0F0F_1234);
    do_read(32'h0000_0005, 32'hDEAD_BEEF);
  endtask

  task automatic test_wrap();
    load_mar(32'h0000_0205);
    checks++;
    if (mar_out !== 9'h005) begin
      errors++;
      $display("FAIL mar_wrap: got %h expected %h", mar_out, 9'h005);
    end
    do_write(32'h0000_0205, 32'h1234_5678);
    do_read(32'h0000_0005, 32'h1234_5678);
  endtask

  task automatic test_busy_protection();
    int rc;
    int n;
    exp_t e;
    rc = ready_count;
    load_mar(32'h5);
    mem_read = 1'b1;
    e.is_read = 1'b1; e.data = 32'h1234_5678; exp_q.push_back(e);
    cyc();
    mem_read = 1'b0; bus_in = 32'hFFFF_FFFF; mdri = 1'b1;
    cyc();
    mdri = 1'b0; mem_read = 1'b1; bus_in = 32'h10; mari = 1'b1;
    cyc();
    mem_read = 1'b0; mari = 1'b0;
    checks++;
    if (mem_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_ready_timing: mem_ready=%b expected 1", mem_ready);
    end
    checks++;
    if (mdr_out !== 32'h1234_5678 || mar_out !== 9'h010) begin
      errors++;
      $display("FAIL busy_protect: mdr=%h mar=%h expected 12345678/010", mdr_out, mar_out);
    end
    n = 0;
    repeat (8) cyc();
    checks++;
    if (ready_count - rc != 1) begin
      errors++;
      $display("FAIL busy_drop: pulses=%0d expected 1", ready_count - rc);
    end
  endtask

  task automatic test_conflict();
    load_mar(32'h5);
    load_mdr(32'hAAAA_5555);
    mem_read = 1'b1; mem_write = 1'b1;
    cyc();
    mem_read = 1'b0; mem_write = 1'b0;
    checks++;
    if (conflict !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_set: conflict=%b busy=%b expected 1/0", conflict, busy);
    end
    repeat (3) cyc();
    checks++;
    if (conflict !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL conflict_sticky: conflict=%b busy=%b expected 1/0", conflict, busy);
    end
    do_read(32'h5, 32'h1234_5678);
    checks++;
    if (conflict !== 1'b1) begin
      errors++;
      $display("FAIL conflict_hold: conflict=%b expected 1", conflict);
    end
    apply_reset();
    checks++;
    if (conflict !== 1'b0) begin
      errors++;
      $display("FAIL conflict_clear: conflict=%b expected 0", conflict);
    end
  endtask

  task automatic test_write_abort();
    do_write(32'h7, 32'hA5A5_A5A5);
    load_mar(32'h7);
    load_mdr(32'h0BAD_F00D);
    mem_write = 1'b1;
    cyc();
    mem_write = 1'b0;
    #1 reset = 1'b1;
    cyc();
    reset = 1'b0;
    cyc();
    do_read(32'h7, 32'hA5A5_A5A5);
  endtask

  task automatic test_back_to_back();
    int pulse_at[3];
    int np;
    int idle_between;
    exp_t e;
    load_mar(32'h0000_0205);
    e.is_read = 1'b1; e.data = 32'h1234_5678;
    repeat (3) exp_q.push_back(e);
    mem_read = 1'b1;
    np = 0;
    idle_between = 0;
    for (int c = 1; c <= 40 && np < 3; c++) begin
      cyc();
      if (np == 1 && busy === 1'b0) idle_between++;
      if (mem_ready) begin
        pulse_at[np] = c;
        np++;
      end
    end
    mem_read = 1'b0;
    checks++;
    if (np != 3) begin
      errors++;
      $display("FAIL held_pulses: got %0d pulses expected 3", np);
    end else begin
      checks++;
      if (pulse_at[1] - pulse_at[0] != RL + 2 || pulse_at[2] - pulse_at[1] != RL + 2) begin
        errors++;
        $display("FAIL held_period: got %0d,%0d expected %0d", pulse_at[1] - pulse_at[0],
                 pulse_at[2] - pulse_at[1], RL + 2);
      end
      checks++;
      if (idle_between != 1) begin
        errors++;
        $display("FAIL held_idle_gap: got %0d idle cycles expected 1", idle_between);
      end
    end
    repeat (4) cyc();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_wrap();
    test_busy_protection();
    test_conflict();
    test_write_abort();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected completions never seen, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
